// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg: shared register-file types, constants and state encodings
package hsv_core_pkg;
  typedef logic [4:0] reg_addr;
  typedef logic [31:0] word;
  localparam word REG_ZERO = '0;
  typedef enum logic {RF_INIT, RF_READY} regfile_state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_BYP, SRC_BANK} rd_src_t;
endpackage

// File: rtl/hsv_core_regfile_mp_if.sv
// hsv_core_regfile_mp_if: read/write port bundle of the multi-port register file
interface hsv_core_regfile_mp_if #(
  parameter int NUM_READ_PORTS = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_READ_PORTS-1:0] rd_hold;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic ready;
  modport master (output rd_addr, rd_hold, wr_en, wr_addr, wr_data, input rd_data, ready);
  modport slave (input rd_addr, rd_hold, wr_en, wr_addr, wr_data, output rd_data, ready);
endinterface

// File: rtl/hsv_core_regfile_bank.sv
// hsv_core_regfile_bank: one-write one-sync-read memory bank without reset
module hsv_core_regfile_bank #(
  parameter int NUM_REGS = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic clk_core,
  input  logic rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  // read returns the pre-write word; a disabled read keeps the last word
  always_ff @(posedge clk_core) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/hsv_core_regfile_mp.sv
// hsv_core_regfile_mp: replicated-bank register file with zero reg, bypass, hold and clear sweep
module hsv_core_regfile_mp
  import hsv_core_pkg::*;
#(
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_REGS = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1
) (
  input logic clk_core,
  input logic rst_n,
  hsv_core_regfile_mp_if.slave rf
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  regfile_state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic init, wr_eff, bank_we;
  logic [ADDR_W-1:0] bank_wa;
  logic [DATA_WIDTH-1:0] bank_wd;
  assign init = state == RF_INIT;
  assign wr_eff = !init && rf.wr_en && !(ZERO_REG && rf.wr_addr == '0) && (int'(rf.wr_addr) < NUM_REGS);
  assign rf.ready = state == RF_READY;
  // state register and clear-sweep counter
  always_ff @(posedge clk_core or negedge rst_n)
    if (!rst_n) begin
      state <= RF_INIT;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= init ? cnt + 1'b1 : cnt;
    end
  // next state and bank write-port mux: sweep zeros while INIT, user writes after
  always_comb begin
    state_nxt = (init && cnt == LAST) ? RF_READY : state;
    bank_we = init || wr_eff;
    bank_wa = init ? cnt : rf.wr_addr;
    bank_wd = init ? DATA_WIDTH'(REG_ZERO) : rf.wr_data;
  end
  for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic rd_zero;
    logic [DATA_WIDTH-1:0] bank_q, byp_q;
    rd_src_t src;
    assign ra = rf.rd_addr[i];
    assign rd_zero = init || (ZERO_REG && ra == '0) || (int'(ra) >= NUM_REGS);
    hsv_core_regfile_bank #(
      .NUM_REGS(NUM_REGS),
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk_core(clk_core),
      .rd_en(!rf.rd_hold[i]),
      .rd_addr(rd_zero ? '0 : ra),
      .rd_data(bank_q),
      .wr_en(bank_we),
      .wr_addr(bank_wa),
      .wr_data(bank_wd)
    );
    // registered output source and bypass word, frozen together with the bank read while held
    always_ff @(posedge clk_core or negedge rst_n)
      if (!rst_n) begin
        src <= SRC_ZERO;
        byp_q <= '0;
      end else if (!rf.rd_hold[i]) begin
        src <= rd_zero ? SRC_ZERO : (BYPASS && wr_eff && rf.wr_addr == ra) ? SRC_BYP : SRC_BANK;
        byp_q <= rf.wr_data;
      end
    assign rf.rd_data[i] = src == SRC_BANK ? bank_q : src == SRC_BYP ? byp_q : '0;
  end
endmodule
